// File: rtl/mips_multicycle_ctrl_if.sv
// Control bus between the multicycle MIPS controller and its datapath.
// The controller (master) drives every enable/select and reads the
// instruction fields plus the ALU zero flag; the datapath (slave) mirrors it.
interface mips_multicycle_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       pcen;
    logic [3:0] state;

    modport master (
        input  op, funct, zero,
        output iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, alucontrol, pcen, state
    );

    modport slave (
        output op, funct, zero,
        input  iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, alucontrol, pcen, state
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: Moore sequencer plus ALU decoder.
// Outputs are decoded from the state register; only pcen also depends on
// the live zero flag (meaningful in BEQEX). While reset_n is low every
// output, including state, is forced to zero so no pending write escapes.
module mips_multicycle_ctrl (
    input  logic                  clk,
    input  logic                  reset_n,
    mips_multicycle_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t state_q, state_d;
    // Remembers lw vs sw from DECODE so MEMADR does not re-read op.
    logic   is_lw_q, is_lw_d;

    // ALU control encoding as expected by the ALU's mux tree.
    function automatic logic [2:0] alu_decode(input logic [1:0] aluop,
                                              input logic [5:0] fn);
        logic [2:0] res;
        res = 3'b010;
        case (aluop)
            2'b00: res = 3'b010;
            2'b01: res = 3'b110;
            2'b10: begin
                case (fn)
                    6'b100000: res = 3'b010;
                    6'b100010: res = 3'b110;
                    6'b100100: res = 3'b001;
                    6'b100101: res = 3'b000;
                    6'b101010: res = 3'b111;
                    default:   res = 3'b010;
                endcase
            end
            default: res = 3'b010;
        endcase
        return res;
    endfunction

    // State and load/store flag registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
            is_lw_q <= 1'b0;
        end else begin
            state_q <= state_d;
            is_lw_q <= is_lw_d;
        end
    end

    // Next-state selection; op is only consulted in DECODE.
    always_comb begin
        state_d = S_FETCH;
        is_lw_d = is_lw_q;
        case (state_q)
            S_FETCH:   state_d = S_DECODE;
            S_DECODE: begin
                is_lw_d = (bus.op == OP_LW);
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (is_lw_q) begin
                    state_d = S_MEMRD;
                end else begin
                    state_d = S_MEMWR;
                end
            end
            S_MEMRD:   state_d = S_MEMWB;
            S_RTYPEEX: state_d = S_RTYPEWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    // Moore output decode, pcen from branch & zero, reset gating last.
    always_comb begin
        logic       pcwrite_s;
        logic       branch_s;
        logic [1:0] aluop_s;

        pcwrite_s      = 1'b0;
        branch_s       = 1'b0;
        aluop_s        = 2'b00;
        bus.iord       = 1'b0;
        bus.memwrite   = 1'b0;
        bus.irwrite    = 1'b0;
        bus.regdst     = 1'b0;
        bus.memtoreg   = 1'b0;
        bus.regwrite   = 1'b0;
        bus.alusrca    = 1'b0;
        bus.alusrcb    = 2'b00;
        bus.pcsrc      = 2'b00;
        bus.alucontrol = 3'b000;
        bus.pcen       = 1'b0;
        bus.state      = 4'd0;

        case (state_q)
            S_FETCH: begin
                bus.irwrite = 1'b1;
                bus.alusrcb = 2'b01;
                pcwrite_s   = 1'b1;
            end
            S_DECODE:  bus.alusrcb = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
            end
            S_MEMRD:   bus.iord = 1'b1;
            S_MEMWB: begin
                bus.memtoreg = 1'b1;
                bus.regwrite = 1'b1;
            end
            S_MEMWR: begin
                bus.iord     = 1'b1;
                bus.memwrite = 1'b1;
            end
            S_RTYPEEX: begin
                bus.alusrca = 1'b1;
                aluop_s     = 2'b10;
            end
            S_RTYPEWB: begin
                bus.regdst   = 1'b1;
                bus.regwrite = 1'b1;
            end
            S_BEQEX: begin
                bus.alusrca = 1'b1;
                aluop_s     = 2'b01;
                bus.pcsrc   = 2'b01;
                branch_s    = 1'b1;
            end
            S_ADDIWB:  bus.regwrite = 1'b1;
            S_JEX: begin
                bus.pcsrc = 2'b10;
                pcwrite_s = 1'b1;
            end
            default: begin
                pcwrite_s = 1'b0;
            end
        endcase

        bus.alucontrol = alu_decode(aluop_s, bus.funct);
        bus.pcen       = pcwrite_s | (branch_s & bus.zero);
        bus.state      = state_q;

        if (!reset_n) begin
            bus.iord       = 1'b0;
            bus.memwrite   = 1'b0;
            bus.irwrite    = 1'b0;
            bus.regdst     = 1'b0;
            bus.memtoreg   = 1'b0;
            bus.regwrite   = 1'b0;
            bus.alusrca    = 1'b0;
            bus.alusrcb    = 2'b00;
            bus.pcsrc      = 2'b00;
            bus.alucontrol = 3'b000;
            bus.pcen       = 1'b0;
            bus.state      = 4'd0;
        end else begin
            bus.state      = state_q;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: walks each instruction class
// cycle by cycle and compares state and a packed output word against
// hand-written expected values.
module tb_mips_multicycle_ctrl;

    logic clk;
    logic reset_n;
    int   checks_r;
    int   errors_r;

    mips_multicycle_ctrl_if dif ();

    mips_multicycle_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (dif.master)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Packed output word:
    // {iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,pcsrc,alucontrol,pcen}
    function automatic logic [14:0] ev(input logic iord, input logic mw,
                                       input logic irw, input logic rd,
                                       input logic m2r, input logic rw,
                                       input logic asa, input logic [1:0] asb,
                                       input logic [1:0] ps, input logic [2:0] ac,
                                       input logic pcen);
        return {iord, mw, irw, rd, m2r, rw, asa, asb, ps, ac, pcen};
    endfunction

    function automatic logic [14:0] obs_word();
        return {dif.iord, dif.memwrite, dif.irwrite, dif.regdst, dif.memtoreg,
                dif.regwrite, dif.alusrca, dif.alusrcb, dif.pcsrc,
                dif.alucontrol, dif.pcen};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        checks_r++;
        if (obs !== exp) begin
            errors_r++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check current state/outputs, then advance one clock.
    task automatic cyc(input string tag, input logic [3:0] st,
                       input logic [14:0] outs);
        check_val({tag, "_state"}, {28'd0, dif.state}, {28'd0, st});
        check_val({tag, "_outs"}, {17'd0, obs_word()}, {17'd0, outs});
        @(posedge clk);
        #1;
    endtask

    logic [14:0] e_fetch, e_decode, e_memadr, e_memrd, e_memwb, e_memwr;
    logic [14:0] e_rtypewb, e_addiex, e_addiwb, e_jex, e_zero;
    logic [5:0]  fn_tab [6];
    logic [2:0]  ac_tab [6];

    initial begin
        checks_r = 0;
        errors_r = 0;
        e_fetch   = ev(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,3'b010,1'b1);
        e_decode  = ev(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,3'b010,1'b0);
        e_memadr  = ev(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,3'b010,1'b0);
        e_memrd   = ev(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,3'b010,1'b0);
        e_memwb   = ev(1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,3'b010,1'b0);
        e_memwr   = ev(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,3'b010,1'b0);
        e_rtypewb = ev(1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,3'b010,1'b0);
        e_addiex  = e_memadr;
        e_addiwb  = ev(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,3'b010,1'b0);
        e_jex     = ev(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,3'b010,1'b1);
        e_zero    = 15'd0;
        fn_tab[0] = 6'b100000; ac_tab[0] = 3'b010;
        fn_tab[1] = 6'b100010; ac_tab[1] = 3'b110;
        fn_tab[2] = 6'b100100; ac_tab[2] = 3'b001;
        fn_tab[3] = 6'b100101; ac_tab[3] = 3'b000;
        fn_tab[4] = 6'b101010; ac_tab[4] = 3'b111;
        fn_tab[5] = 6'b000000; ac_tab[5] = 3'b010;

        // Reset held for three cycles with an lw opcode present.
        reset_n  = 1'b0;
        dif.op   = 6'b100011;
        dif.funct = 6'b000000;
        dif.zero = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            cyc("reset", 4'd0, e_zero);
        end
        reset_n = 1'b1;
        #1;

        // lw; op is scrambled after DECODE and must not matter.
        dif.op = 6'b100011;
        cyc("lw_fetch", 4'd0, e_fetch);
        cyc("lw_decode", 4'd1, e_decode);
        dif.op = 6'b111111;
        cyc("lw_memadr", 4'd2, e_memadr);
        cyc("lw_memrd", 4'd3, e_memrd);
        cyc("lw_memwb", 4'd4, e_memwb);

        // sw
        dif.op = 6'b101011;
        cyc("sw_fetch", 4'd0, e_fetch);
        cyc("sw_decode", 4'd1, e_decode);
        dif.op = 6'b100011;
        cyc("sw_memadr", 4'd2, e_memadr);
        cyc("sw_memwr", 4'd5, e_memwr);

        // R-type sweep; funct changes in RTYPEWB must not alter alucontrol.
        for (int k = 0; k < 6; k++) begin
            dif.op    = 6'b000000;
            dif.funct = 6'b100010;
            cyc("rt_fetch", 4'd0, e_fetch);
            cyc("rt_decode", 4'd1, e_decode);
            dif.funct = fn_tab[k];
            #1;
            cyc($sformatf("rt_ex_%0d", k), 4'd6,
                ev(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,ac_tab[k],1'b0));
            dif.funct = 6'b101010;
            cyc("rt_wb", 4'd7, e_rtypewb);
        end

        // beq taken and not taken.
        for (int z = 1; z >= 0; z--) begin
            dif.op   = 6'b000100;
            dif.zero = z[0];
            cyc("beq_fetch", 4'd0, e_fetch);
            cyc("beq_decode", 4'd1, e_decode);
            cyc($sformatf("beq_ex_z%0d", z), 4'd8,
                ev(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,3'b110,z[0]));
        end
        dif.zero = 1'b1;

        // addi
        dif.op = 6'b001000;
        cyc("addi_fetch", 4'd0, e_fetch);
        cyc("addi_decode", 4'd1, e_decode);
        cyc("addi_ex", 4'd9, e_addiex);
        cyc("addi_wb", 4'd10, e_addiwb);

        // j
        dif.op = 6'b000010;
        cyc("j_fetch", 4'd0, e_fetch);
        cyc("j_decode", 4'd1, e_decode);
        cyc("j_ex", 4'd11, e_jex);

        // illegal opcode returns to FETCH after DECODE.
        dif.op = 6'b111111;
        cyc("ill_fetch", 4'd0, e_fetch);
        cyc("ill_decode", 4'd1, e_decode);

        // Reset in MEMRD of an lw.
        dif.op = 6'b100011;
        cyc("mr_fetch", 4'd0, e_fetch);
        cyc("mr_decode", 4'd1, e_decode);
        cyc("mr_memadr", 4'd2, e_memadr);
        check_val("mr_memrd_state", {28'd0, dif.state}, 32'd3);
        reset_n = 1'b0;
        #1;
        check_val("mr_rst_now", {17'd0, obs_word()}, 32'd0);
        check_val("mr_rst_state", {28'd0, dif.state}, 32'd0);
        @(posedge clk);
        #1;
        check_val("mr_rst_edge_outs", {17'd0, obs_word()}, 32'd0);
        reset_n = 1'b1;
        #1;
        cyc("post_fetch", 4'd0, e_fetch);
        cyc("post_decode", 4'd1, e_decode);
        cyc("post_memadr", 4'd2, e_memadr);
        cyc("post_memrd", 4'd3, e_memrd);
        cyc("post_memwb", 4'd4, e_memwb);
        cyc("post_next", 4'd0, e_fetch);

        $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multicycle MIPS control unit: a Moore FSM plus ALU decoder that sequences each instruction through fetch, decode, execute, memory and writeback. It drives the 3-bit ALU control bus into the 32-bit ALU and consumes the ALU's `zero` flag, so it sits at the other end of the ALU's control interface. It also drives every datapath enable and mux select: PC, instruction register, memory, register file, ALU source muxes and PC source mux.

## Interface
Parameters: none.

Ports (`name  direction  width  meaning`):
- clk  in  1  single clock; all state changes on rising edge
- reset_n  in  1  synchronous, active-low reset
- op  in  6  instr[31:26], valid from DECODE onward
- funct  in  6  instr[5:0]
- zero  in  1  ALU equality flag (a == b)
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- memwrite  out  1  data memory write strobe
- irwrite  out  1  instruction register load
- regdst  out  1  write register: 0 = rt, 1 = rd
- memtoreg  out  1  write data: 0 = ALUOut, 1 = mem data
- regwrite  out  1  register file write
- alusrca  out  1  ALU a: 0 = PC, 1 = rs
- alusrcb  out  2  ALU b: 00 = rt, 01 = 4, 10 = sign-extended imm, 11 = imm<<2
- pcsrc  out  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target
- alucontrol  out  3  ALU operation select
- pcen  out  1  PC load = pcwrite | (branch & zero)
- state  out  4  current state, for debug and bench

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11. Codes 12–15 are unreachable; if entered, go to FETCH.
- Transitions:
  - FETCH→DECODE.
  - DECODE on op: 100011 lw / 101011 sw → MEMADR; 000000 → RTYPEEX; 000100 → BEQEX; 001000 → ADDIEX; 000010 → JEX; any other opcode → FETCH (no-op).
  - MEMADR→MEMRD (lw) or MEMWR (sw). MEMRD→MEMWB.
  - RTYPEEX→RTYPEWB. ADDIEX→ADDIWB.
  - MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB, JEX → FETCH.
- Per-state outputs (anything not listed is 0; aluop=00 unless listed):
  - FETCH: irwrite=1, alusrcb=01, pcwrite=1, pcsrc=00
  - DECODE: alusrcb=11
  - MEMADR, ADDIEX: alusrca=1, alusrcb=10
  - MEMRD: iord=1
  - MEMWB: memtoreg=1, regwrite=1
  - MEMWR: iord=1, memwrite=1
  - RTYPEEX: alusrca=1, alusrcb=00, aluop=10
  - RTYPEWB: regdst=1, regwrite=1
  - BEQEX: alusrca=1, aluop=01, pcsrc=01, branch=1
  - ADDIWB: regwrite=1
  - JEX: pcsrc=10, pcwrite=1
- ALU decoder (combinational), fixed by the ALU's mux tree:
  - aluop=00 → 010 (add); aluop=01 → 110 (sub).
  - aluop=10 → by funct: 100000→010, 100010→110, 100100→001 (and), 100101→000 (or), 101010→111 (slt); any other funct → 010.
  - aluop=11 never occurs; decode it as 010.
- Cycles per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal opcode 2.

## Timing
- Moore outputs decode from the state register; `pcen` alone is combinational on `zero`, valid only in BEQEX.
- Reset: the state register loads FETCH on a clk edge while reset_n=0.
- While reset_n=0, all outputs are forced to 0 combinationally and `state` reads 0. This holds even mid-instruction: no pending regwrite or memwrite may reach the datapath.
- First cycle after reset_n rises: FETCH outputs (irwrite=1, pcen=1, alucontrol=010, alusrcb=01).
- op and funct are sampled only in DECODE and RTYPEEX respectively. Changes in other states have no effect on the sequence.
- Each output is asserted for exactly one cycle per occurrence of its state, with no glitch across state boundaries.

## Test plan
1. Hold reset_n=0 for 3 cycles with op=100011 → every output 0, state=0. Release → next cycle shows FETCH values (irwrite=1, pcen=1, alucontrol=010).
2. lw (op=100011) → states 0,1,2,3,4,0. In MEMADR: alusrca=1, alusrcb=10. In MEMRD: iord=1. In MEMWB: regwrite=1, memtoreg=1. memwrite=0 throughout. Then sw (101011) → states 0,1,2,5,0 with memwrite=1 only in state 5.
3. R-type sweep: funct 100000 / 100010 / 100100 / 100101 / 101010 → alucontrol 010 / 110 / 001 / 000 / 111 in RTYPEEX, then regdst=1, regwrite=1 in RTYPEWB. funct=000000 → 010.
4. beq (000100) with zero=1 → BEQEX shows pcsrc=01, alucontrol=110, pcen=1. Repeat with zero=0 → pcen=0. Both return to FETCH next cycle.
5. j (000010) → JEX shows pcsrc=10, pcen=1, 3 cycles total. op=111111 → DECODE→FETCH with no regwrite, memwrite or pcen in DECODE.
6. Reset mid-instruction: reset_n=0 during MEMRD of an lw → outputs 0 immediately, state=FETCH after the edge, regwrite never asserted. After release the next instruction sequences normally.
